// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multicycle control unit and its datapath
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
               alu_src_a, alu_src_b, ext_zero, alu_op, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
               alu_src_a, alu_src_b, ext_zero, alu_op, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM driving datapath selects and enables
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master ctl
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    state_t     state_q;
    state_t     state_d;
    logic       is_store_q;
    logic [2:0] r_alu_q;
    logic [2:0] r_alu_d;

    logic       pc_we_c;
    logic [1:0] pc_src_c;
    logic       iord_c;
    logic       mem_we_c;
    logic       ir_we_c;
    logic [1:0] reg_dst_c;
    logic [1:0] mem_to_reg_c;
    logic       reg_we_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic       ext_zero_c;
    logic [2:0] alu_op_c;
    logic       illegal_c;

    // opcode/funct are only trusted at the DECODE edge, so what later states need is captured then
    always_comb begin
        r_alu_d = ALU_ADD;
        case (ctl.funct)
            FN_SUB:  r_alu_d = ALU_SUB;
            FN_SLT:  r_alu_d = ALU_SLT;
            default: r_alu_d = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
            r_alu_q    <= ALU_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_store_q <= (ctl.opcode == OP_SW);
                r_alu_q    <= r_alu_d;
            end
        end
    end

    always_comb begin
        state_d      = S_ILLEGAL;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'b00;
        iord_c       = 1'b0;
        mem_we_c     = 1'b0;
        ir_we_c      = 1'b0;
        reg_dst_c    = 2'b00;
        mem_to_reg_c = 2'b00;
        reg_we_c     = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        ext_zero_c   = 1'b0;
        alu_op_c     = ALU_ADD;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we_c     = 1'b1;
                pc_we_c     = 1'b1;
                alu_src_b_c = 2'b01;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // speculative branch target lands in ALUOut for BRANCH to use
                alu_src_b_c = 2'b11;
                case (ctl.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        case (ctl.funct)
                            FN_ADD, FN_SUB, FN_SLT: state_d = S_R_EXEC;
                            FN_JR:                  state_d = S_JR;
                            default:                state_d = S_ILLEGAL;
                        endcase
                    end
                    OP_XORI: state_d = S_I_EXEC;
                    OP_BNE:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    OP_JAL:  state_d = S_JAL;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = is_store_q ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord_c  = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg_c = 2'b01;
                reg_we_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord_c   = 1'b1;
                mem_we_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = r_alu_q;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_dst_c = 2'b01;
                reg_we_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                ext_zero_c  = 1'b1;
                alu_op_c    = ALU_XOR;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_we_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = 2'b01;
                pc_we_c     = ~ctl.zero;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_c = 2'b10;
                pc_we_c  = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value
                pc_src_c     = 2'b10;
                pc_we_c      = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
                reg_we_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                pc_src_c = 2'b11;
                pc_we_c  = 1'b1;
                state_d  = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                state_d   = S_ILLEGAL;
            end
            default: state_d = S_ILLEGAL;
        endcase
    end

    // reset masks every output in the same cycle so an aborted instruction cannot write
    assign ctl.pc_we      = reset ? 1'b0  : pc_we_c;
    assign ctl.pc_src     = reset ? 2'b00 : pc_src_c;
    assign ctl.iord       = reset ? 1'b0  : iord_c;
    assign ctl.mem_we     = reset ? 1'b0  : mem_we_c;
    assign ctl.ir_we      = reset ? 1'b0  : ir_we_c;
    assign ctl.reg_dst    = reset ? 2'b00 : reg_dst_c;
    assign ctl.mem_to_reg = reset ? 2'b00 : mem_to_reg_c;
    assign ctl.reg_we     = reset ? 1'b0  : reg_we_c;
    assign ctl.alu_src_a  = reset ? 1'b0  : alu_src_a_c;
    assign ctl.alu_src_b  = reset ? 2'b00 : alu_src_b_c;
    assign ctl.ext_zero   = reset ? 1'b0  : ext_zero_c;
    assign ctl.alu_op     = reset ? 3'b000 : alu_op_c;
    assign ctl.illegal    = reset ? 1'b0  : illegal_c;
    assign ctl.state      = reset ? 4'd0  : state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control against an instruction-level model
module tb_multicycle_control;
    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_we;
        logic       ir_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    typedef enum int {K_LW, K_SW, K_R, K_XORI, K_BNE, K_J, K_JAL, K_JR, K_ILL} kind_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    ctl_t act;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        act = '{bus.pc_we, bus.pc_src, bus.iord, bus.mem_we, bus.ir_we, bus.reg_dst,
                bus.mem_to_reg, bus.reg_we, bus.alu_src_a, bus.alu_src_b, bus.ext_zero,
                bus.alu_op, bus.illegal, bus.state};
    end

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h0E: return K_XORI;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return K_R;
                if (fn == 6'h08) return K_JR;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    // cycles observed per instruction; an illegal one is watched for 10 cycles past DECODE
    function automatic int instr_len(input kind_t k);
        case (k)
            K_LW:                return 5;
            K_SW, K_R, K_XORI:   return 4;
            K_ILL:               return 12;
            default:             return 3;
        endcase
    endfunction

    function automatic ctl_t expect_cycle(input kind_t kind, input int k, input logic [5:0] fn, input logic z);
        ctl_t e = '0;
        if (k == 0) begin
            e.ir_we = 1; e.pc_we = 1; e.alu_src_b = 2'b01; e.state = 4'd0;
            return e;
        end
        if (k == 1) begin
            e.alu_src_b = 2'b11; e.state = 4'd1;
            return e;
        end
        case (kind)
            K_LW, K_SW: begin
                if (k == 2) begin
                    e.alu_src_a = 1; e.alu_src_b = 2'b10; e.state = 4'd2;
                end else if (kind == K_SW) begin
                    e.iord = 1; e.mem_we = 1; e.state = 4'd5;
                end else if (k == 3) begin
                    e.iord = 1; e.state = 4'd3;
                end else begin
                    e.mem_to_reg = 2'b01; e.reg_we = 1; e.state = 4'd4;
                end
            end
            K_R: begin
                if (k == 2) begin
                    e.alu_src_a = 1;
                    e.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
                    e.state = 4'd6;
                end else begin
                    e.reg_dst = 2'b01; e.reg_we = 1; e.state = 4'd7;
                end
            end
            K_XORI: begin
                if (k == 2) begin
                    e.alu_src_a = 1; e.alu_src_b = 2'b10; e.ext_zero = 1; e.alu_op = 3'd2; e.state = 4'd8;
                end else begin
                    e.reg_we = 1; e.state = 4'd9;
                end
            end
            K_BNE: begin
                e.alu_src_a = 1; e.alu_op = 3'd1; e.pc_src = 2'b01; e.pc_we = ~z; e.state = 4'd10;
            end
            K_J:   begin e.pc_src = 2'b10; e.pc_we = 1; e.state = 4'd11; end
            K_JAL: begin
                e.pc_src = 2'b10; e.pc_we = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.reg_we = 1; e.state = 4'd12;
            end
            K_JR:  begin e.pc_src = 2'b11; e.pc_we = 1; e.state = 4'd13; end
            default: begin e.illegal = 1; e.state = 4'd15; end
        endcase
        return e;
    endfunction

    // holds reset for n cycles checking everything is masked, then releases right after an edge
    task automatic do_reset(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            bus.zero = 1'($urandom);
            #1;
            n_tests++;
            if (act !== ctl_t'(0)) begin
                n_fail++;
                $display("FAIL %s reset cycle %0d: got %h expected %h", name, i, act, ctl_t'(0));
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // zmode: 0/1 fixed zero, 2 random per cycle; abort_at: cycle index at which reset is asserted, -1 none
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int abort_at);
        kind_t kind = classify(op, fn);
        int    n = instr_len(kind);
        ctl_t  exp;
        logic  z;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.opcode = (k == 1) ? op : 6'($urandom);
            bus.funct  = (k == 1) ? fn : 6'($urandom);
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            bus.zero = z;
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                n_tests++;
                if (act !== ctl_t'(0)) begin
                    n_fail++;
                    $display("FAIL %s abort cycle %0d: got %h expected %h", name, k, act, ctl_t'(0));
                end
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            #1;
            exp = expect_cycle(kind, k, fn, z);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset("reset", 2);
        run_instr("first_after_reset_j", 6'h02, 6'h00, 2, -1);
    endtask

    task automatic test_rtype();
        run_instr("r_sub", 6'h00, 6'h22, 2, -1);
        run_instr("r_add", 6'h00, 6'h20, 2, -1);
        run_instr("r_slt", 6'h00, 6'h2A, 2, -1);
        run_instr("xori", 6'h0E, 6'h15, 2, -1);
    endtask

    task automatic test_mem();
        run_instr("lw", 6'h23, 6'h01, 2, -1);
        run_instr("sw", 6'h2B, 6'h3F, 2, -1);
        run_instr("lw_again", 6'h23, 6'h2A, 2, -1);
    endtask

    task automatic test_branch();
        run_instr("bne_taken", 6'h05, 6'h00, 0, -1);
        run_instr("bne_not_taken", 6'h05, 6'h00, 1, -1);
    endtask

    task automatic test_jumps();
        run_instr("jal", 6'h03, 6'h00, 2, -1);
        run_instr("jr", 6'h00, 6'h08, 2, -1);
        run_instr("j", 6'h02, 6'h11, 2, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 6'h3F, 6'h00, 2, -1);
        do_reset("illegal_op_reset", 1);
        run_instr("after_illegal_lw", 6'h23, 6'h00, 2, -1);
        run_instr("illegal_funct", 6'h00, 6'h3F, 2, -1);
        do_reset("illegal_funct_reset", 1);
    endtask

    task automatic test_reset_abort();
        run_instr("abort_lw_mem_wb", 6'h23, 6'h00, 2, 4);
        run_instr("after_abort_r", 6'h00, 6'h22, 2, -1);
        run_instr("abort_sw_mem_write", 6'h2B, 6'h00, 2, 3);
        run_instr("abort_jal", 6'h03, 6'h00, 2, 2);
        run_instr("after_abort_sw", 6'h2B, 6'h00, 2, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'h23, 6'h2B, 6'h00, 6'h0E, 6'h05, 6'h02, 6'h03, 6'h00};
        logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h2A, 6'h08};
        for (int i = 0; i < 200; i++) begin
            int         r = int'($urandom_range(0, 9));
            logic [5:0] op;
            logic [5:0] fn = 6'($urandom);
            kind_t      kind;
            int         abort = -1;
            if (r < 8) begin
                op = ops[r];
                if (op == 6'h00) fn = fns[$urandom_range(0, 3)];
            end else begin
                op = 6'($urandom);
            end
            kind = classify(op, fn);
            if ($urandom_range(0, 9) == 0) abort = int'($urandom_range(1, 2));
            run_instr($sformatf("rand%0d_op%02h_fn%02h", i, op, fn), op, fn, 2, abort);
            if (kind == K_ILL && abort < 0) do_reset("rand_illegal_reset", 1);
        end
    endtask

    initial begin
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        test_reset();
        test_rtype();
        test_mem();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS-subset control unit: a Moore/Mealy FSM that sequences each instruction over 3–5 cycles. It drives every datapath mux select (the 2:1, 3:1 and 4:1 32-bit selectors), register and memory write enables, and the ALU operation. It sits directly upstream of the datapath muxes and consumes opcode/funct from the instruction register and the ALU zero flag.

## Interface
- No parameters; encodings below are fixed.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; priority over all other inputs
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, combinational from current ALU inputs
- pc_we  output  1  PC write enable
- pc_src  output  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A
- iord  output  1  memory address mux: 0 PC, 1 ALUOut
- mem_we  output  1  memory write enable
- ir_we  output  1  IR write enable
- reg_dst  output  2  write-register mux: 00 rt, 01 rd, 10 constant 31
- mem_to_reg  output  2  write-data mux: 00 ALUOut, 01 MDR, 10 PC
- reg_we  output  1  register file write enable
- alu_src_a  output  1  0 PC, 1 register A
- alu_src_b  output  2  00 register B, 01 constant 4, 10 extended imm, 11 sign-extended imm<<2
- ext_zero  output  1  immediate extender: 1 zero-extend, 0 sign-extend
- alu_op  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- illegal  output  1  sticky unsupported-instruction flag
- state  output  4  current state code, for debug

## Operation
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JAL 12, JR 13, ILLEGAL 15. Code 14 is unused and goes to ILLEGAL.
- Every output not listed for a state is 0.
- FETCH: ir_we=1, alu_src_b=01, pc_we=1 (pc_src=00, PC+4). Next state DECODE.
- DECODE: alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 0x23 LW or 0x2B SW → MEM_ADDR
  - 0x00 → R_EXEC for funct 0x20/0x22/0x2A; JR for funct 0x08; ILLEGAL for any other funct
  - 0x0E XORI → I_EXEC
  - 0x05 BNE → BRANCH
  - 0x02 J → JUMP
  - 0x03 JAL → JAL
  - any other opcode → ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next: LW → MEM_READ; SW → MEM_WRITE.
- MEM_READ: iord=1. Next MEM_WB.
- MEM_WB: mem_to_reg=01, reg_we=1. Next FETCH.
- MEM_WRITE: iord=1, mem_we=1. Next FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct (0x20 ADD, 0x22 SUB, 0x2A SLT). Next R_WB.
- R_WB: reg_dst=01, reg_we=1. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, ext_zero=1, XOR. Next I_WB.
- I_WB: reg_we=1. Next FETCH.
- BRANCH: alu_src_a=1, SUB, pc_src=01, pc_we=~zero (Mealy; the only input-dependent output). Next FETCH.
- JUMP: pc_src=10, pc_we=1. Next FETCH.
- JAL: pc_src=10, pc_we=1, reg_dst=10, mem_to_reg=10, reg_we=1. Writes the already-incremented PC. Next FETCH.
- JR: pc_src=11, pc_we=1. Next FETCH.
- ILLEGAL: illegal=1, all enables 0. Self-loop until reset.

## Timing
- State register updates on the rising clk edge. Outputs are combinational from state (plus zero in BRANCH). They are valid within the same cycle.
- Reset: on the edge where reset=1, state becomes FETCH. While reset=1, all enables (pc_we, ir_we, mem_we, reg_we) and all selects are forced 0, illegal=0, and state reads 0.
- The first FETCH cycle is the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts it. No write enable asserts in that cycle or later until FETCH.
- opcode/funct are sampled only at the DECODE→next transition. They must be stable from IR by then, since ir_we was in the previous cycle. zero is sampled only in BRANCH.
- Cycles per instruction, FETCH to the last state inclusive:
  - LW: 5
  - SW, R-type, XORI: 4
  - BNE, J, JAL, JR: 3
- Exactly one pc_we pulse per FETCH. At most one more pc_we per instruction.

## Test plan
- Reset held 2 cycles, released → state=0. Cycle 1 after release: ir_we=1, pc_we=1, alu_src_b=01. No enables high during reset.
- opcode 0x00, funct 0x22 (SUB) → states 0,1,6,7,0. In state 6, alu_op=001. In state 7, reg_dst=01 and reg_we=1.
- opcode 0x23 → 0,1,2,3,4. In state 3, iord=1. In state 4, mem_to_reg=01 and reg_we=1. Then opcode 0x2B → state 5 with mem_we=1, iord=1.
- opcode 0x05 with zero=0 → BRANCH pc_we=1, pc_src=01. Repeat with zero=1 → pc_we=0. Both return to FETCH.
- opcode 0x03 → JAL: pc_src=10, reg_dst=10, mem_to_reg=10, reg_we=1. Then funct 0x08 → JR with pc_src=11.
- opcode 0x3F → ILLEGAL: illegal=1, state=15, enables 0 for 10 cycles. Then reset → state=0, illegal=0. Also assert reset during MEM_WB → reg_we=0 that cycle.
